// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem request port feeding a small
// instruction queue toward decode, with flush-and-restart on redirect.
module fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INST_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
   parameter int unsigned        FQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4,
   output logic [INST_W-1:0] if_instruction
);

   localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
   localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_KILL = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pending_pc;
   logic [ADDR_W-1:0] q_pc   [FQ_DEPTH];
   logic [INST_W-1:0] q_inst [FQ_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;
   logic              req_fire;
   logic [OCC_W-1:0]  occ_nxt;

   // Handshake qualifiers; a request only goes out if its response is guaranteed a slot
   always_comb begin
      push           = imem_rsp_valid && (state == ST_WAIT) && !redirect_valid;
      if_valid       = (count != '0) && !redirect_valid;
      pop            = if_valid && if_ready;
      occ_nxt        = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
      imem_req_valid = rst && !redirect_valid
                       && ((state == ST_IDLE) || ((state == ST_WAIT) && imem_rsp_valid))
                       && (occ_nxt < OCC_W'(FQ_DEPTH));
      req_fire       = imem_req_valid && imem_req_ready;
   end

   // KILL waits out the stale response of a request made before a redirect
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_fire) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid)      state_nxt = imem_rsp_valid ? ST_IDLE : ST_KILL;
            else if (imem_rsp_valid) state_nxt = req_fire ? ST_WAIT : ST_IDLE;
         end
         ST_KILL: begin
            if (imem_rsp_valid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         fetch_pc   <= RESET_PC;
         pending_pc <= RESET_PC;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
      end else begin
         state <= state_nxt;
         if (redirect_valid)  fetch_pc <= redirect_pc;
         else if (req_fire)   fetch_pc <= fetch_pc + ADDR_W'(4);
         if (req_fire)        pending_pc <= fetch_pc;
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= CNT_W'(occ_nxt);
         end
      end
   end

   // Queue payload storage needs no reset; count gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]   <= pending_pc;
         q_inst[wr_ptr] <= imem_rsp_data;
      end
   end

   assign imem_req_addr  = fetch_pc;
   assign if_pc          = q_pc[rd_ptr];
   assign if_pc_plus4    = q_pc[rd_ptr] + ADDR_W'(4);
   assign if_instruction = q_inst[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural imem model, an expected-entry
// queue filled by the directed sequence, and a monitor that checks every pop.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instruction;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   exp_t        exp_q[$];
   int          pop_log[$];
   logic [31:0] exp_req_addr;
   bit          ready_en   = 1'b0;
   int          pulse_at   = -10;
   bit          req_toggle = 1'b0;
   int          mem_lat    = 1;
   bit          pend       = 1'b0;
   logic [31:0] pend_addr  = '0;
   int          left       = 0;
   int          rel_cyc    = 0;
   bit          found;

   fetch_unit #(
      .ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC), .FQ_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instruction(if_instruction)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_seq(input logic [31:0] start, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = start + 32'(4 * i);
         e.pc4  = e.pc + 32'd4;
         e.inst = inst_of(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic expect_one(input logic [31:0] pc, input logic [31:0] pc4);
      exp_t e;
      e.pc   = pc;
      e.pc4  = pc4;
      e.inst = inst_of(pc);
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_remaining", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic settle();
      ready_en   = 1'b0;
      req_toggle = 1'b0;
      repeat (25) step();
      #2;
      check("settle_no_req", 32'(imem_req_valid), 32'd1 - 32'd1);
      check("settle_full_valid", 32'(if_valid), 32'd1);
      check("settle_mem_idle", 32'(pend), 32'd0);
   endtask

   // Memory model: drives at the falling edge, samples handshakes just before the rising edge
   initial begin : mem_model
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if_ready       = 1'b0;
      forever begin
         @(negedge clk);
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_req_ready = req_toggle ? ~imem_req_ready : 1'b1;
         if_ready       = (ready_en || (cyc == pulse_at)) && (exp_q.size() != 0);
         if (!rst) begin
            pend = 1'b0;
         end else if (pend) begin
            if (left <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = inst_of(pend_addr);
               pend           = 1'b0;
            end else begin
               left--;
            end
         end
         #4;
         if (rst && imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req_addr);
            check("one_outstanding", 32'(pend), 32'd0);
            exp_req_addr = exp_req_addr + 32'd4;
            pend         = 1'b1;
            pend_addr    = imem_req_addr;
            left         = mem_lat;
         end
      end
   end

   // Scoreboard monitor: every consumed head must match the oldest expected entry
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (redirect_valid) check("if_valid_in_redirect", 32'(if_valid), 32'd0);
         if (if_valid && if_ready) begin
            pop_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pop actual_pc=%h required=no_entry", if_pc);
            end else begin
               e = exp_q.pop_front();
               check("if_pc", if_pc, e.pc);
               check("if_pc_plus4", if_pc_plus4, e.pc4);
               check("if_instruction", if_instruction, e.inst);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      exp_req_addr   = RST_PC;
      #2 rst = 1'b0;

      // Reset values, then streaming with a 1-cycle memory
      expect_seq(RST_PC, 8);
      ready_en = 1'b1;
      repeat (3) step();
      #2;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, RST_PC);
      step();
      rst = 1'b1;
      #2;
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, RST_PC);
      rel_cyc = cyc;
      wait_drain(60);
      check("pop_log_len", 32'(pop_log.size() >= 8), 32'd1);
      if (pop_log.size() >= 8) begin
         check("first_pop_latency", 32'(pop_log[0]), 32'(rel_cyc + 2));
         check("no_gaps", 32'(pop_log[7] - pop_log[0]), 32'd7);
      end

      // Decode stalled: queue fills to 4 and requests stop; a single pop refills once
      repeat (6) step();
      #2;
      check("full_no_req", 32'(imem_req_valid), 32'd0);
      check("full_if_valid", 32'(if_valid), 32'd1);
      check("full_req_addr", imem_req_addr, 32'h0000_0130);
      step();
      expect_seq(32'h0000_0120, 1);
      pulse_at = cyc + 1;
      step();
      #2;
      check("pulse_req_valid", 32'(imem_req_valid), 32'd1);
      check("pulse_req_addr", imem_req_addr, 32'h0000_0130);
      step();
      #2;
      check("refill_stop", 32'(imem_req_valid), 32'd0);

      // 3-cycle memory with a toggling request ready
      mem_lat    = 3;
      req_toggle = 1'b1;
      expect_seq(32'h0000_0124, 11);
      ready_en = 1'b1;
      wait_drain(200);

      // Redirect in IDLE with a full queue, then redirect while a request is pending
      settle();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1000;
      exp_q.delete();
      exp_req_addr = 32'h0000_1000;
      mem_lat      = 3;
      #2;
      check("redir_idle_if_valid", 32'(if_valid), 32'd0);
      check("redir_idle_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      #2;
      check("redir_idle_req", 32'(imem_req_valid), 32'd1);
      check("redir_idle_addr", imem_req_addr, 32'h0000_1000);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      exp_req_addr   = 32'h0000_2000;
      #2;
      check("redir_wait_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      #2;
      check("kill_no_req", 32'(imem_req_valid), 32'd0);
      step();
      expect_seq(32'h0000_2000, 4);
      ready_en = 1'b1;
      #2;
      check("kill_rsp_no_req", 32'(imem_req_valid), 32'd0);
      check("kill_if_valid", 32'(if_valid), 32'd0);
      step();
      #2;
      check("kill_restart_req", 32'(imem_req_valid), 32'd1);
      check("kill_restart_addr", imem_req_addr, 32'h0000_2000);
      wait_drain(100);

      // Redirect in the same cycle as the response
      settle();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1800;
      exp_q.delete();
      exp_req_addr = 32'h0000_1800;
      mem_lat      = 2;
      step();
      redirect_valid = 1'b0;
      #2;
      check("rr_req_addr", imem_req_addr, 32'h0000_1800);
      check("rr_req_valid", 32'(imem_req_valid), 32'd1);
      step();
      #2;
      check("rr_wait_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      exp_req_addr   = 32'h0000_2000;
      #2;
      check("rr_redir_no_req", 32'(imem_req_valid), 32'd0);
      check("rr_redir_if_valid", 32'(if_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      expect_seq(32'h0000_2000, 2);
      ready_en = 1'b1;
      #2;
      check("rr_next_req", 32'(imem_req_valid), 32'd1);
      check("rr_next_addr", imem_req_addr, 32'h0000_2000);
      mem_lat = 1;
      wait_drain(60);

      // Address wrap at the top of the space
      settle();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      exp_q.delete();
      exp_req_addr = 32'hFFFF_FFF8;
      mem_lat      = 3;
      step();
      redirect_valid = 1'b0;
      expect_one(32'hFFFF_FFF8, 32'hFFFF_FFFC);
      expect_one(32'hFFFF_FFFC, 32'h0000_0000);
      expect_one(32'h0000_0000, 32'h0000_0004);
      expect_one(32'h0000_0004, 32'h0000_0008);
      ready_en = 1'b1;
      #2;
      check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
      wait_drain(100);

      // Asynchronous reset while a request is outstanding and the queue holds data
      ready_en = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (pend && if_valid) found = 1'b1;
      end
      check("wait_with_data_found", 32'(found), 32'd1);
      rst = 1'b0;
      #1;
      check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("async_rst_if_valid", 32'(if_valid), 32'd0);
      check("async_rst_req_addr", imem_req_addr, RST_PC);

      exp_req_addr = RST_PC;
      mem_lat      = 1;
      expect_seq(RST_PC, 4);
      ready_en = 1'b1;
      repeat (2) step();
      step();
      rst = 1'b1;
      #2;
      check("rerelease_req_valid", 32'(imem_req_valid), 32'd1);
      check("rerelease_req_addr", imem_req_addr, RST_PC);
      wait_drain(40);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a variable-latency memory handshake, an instruction queue, back-pressure from decode and a PC redirect. It sits in the IF slot of the pipeline. It drives the instruction-memory request/response port and presents {pc, pc+4, instruction} entries to the IF/ID boundary through a valid/ready handshake. At most one memory request is outstanding at any time.

## Interface
- ADDR_W, 32, PC and memory address width
- INST_W, 32, instruction width
- RESET_PC, {ADDR_W{1'b0}}, first fetch address after reset
- FQ_DEPTH, 4, instruction-queue entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address, word-aligned
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  request address (= fetch_pc)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  INST_W  fetched instruction
- if_valid  out  1  queue head valid
- if_ready  in  1  decode consumes head
- if_pc  out  ADDR_W  head PC
- if_pc_plus4  out  ADDR_W  head PC + 4
- if_instruction  out  INST_W  head instruction

## Operation
- Internal state:
  - fetch_pc register.
  - FSM {IDLE, WAIT, KILL}.
  - Circular queue of FQ_DEPTH entries {pc, instr}, with rd/wr pointers and count (0..FQ_DEPTH).
  - Pending-PC register, which records the address of the outstanding request.
- push = imem_rsp_valid && state==WAIT && !redirect_valid. pop = if_valid && if_ready.
- imem_req_valid = rst && !redirect_valid && (state==IDLE || (state==WAIT && imem_rsp_valid)) && (count + push − pop) < FQ_DEPTH.
  - This is a combinational path from imem_rsp_valid and if_ready; it is intended.
- Request handshake (imem_req_valid && imem_req_ready): pending_pc ← fetch_pc; fetch_pc ← fetch_pc + 4.
- FSM transitions:
  - IDLE → WAIT on handshake.
  - WAIT with rsp: push {pending_pc, rsp_data}. Then WAIT if a handshake occurs in the same cycle, else IDLE.
  - WAIT with redirect and no rsp → KILL. WAIT with redirect and rsp → IDLE; the response is dropped.
  - KILL with rsp → IDLE; the response is dropped and no request is issued.
  - KILL with redirect → stays in KILL.
- Redirect (any state):
  - fetch_pc ← redirect_pc.
  - Queue emptied: count←0, pointers←0.
  - No pop this cycle; if_valid is forced 0 while redirect_valid is high.
- if_valid = (count≠0) && !redirect_valid. The head fields come from the queue head; values are don't-care when if_valid=0.
- Arithmetic:
  - fetch_pc + 4 and if_pc_plus4 wrap modulo 2^ADDR_W.
  - Queue pointers wrap modulo FQ_DEPTH.
- push and pop in the same cycle leave count unchanged. Push never occurs at count==FQ_DEPTH (guaranteed by the request rule).

## Timing
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, state=IDLE, count=0.
  - if_valid=0 and imem_req_valid=0.
  - imem_req_addr=RESET_PC.
- First cycle after rst rises: imem_req_valid=1 with addr RESET_PC.
- Latency: response accepted at edge N → if_valid=1 from cycle N+1.
  - With a 1-cycle memory (rsp in the cycle after the handshake, req_ready=1), first instruction is visible 2 cycles after the request.
  - Steady state is then one instruction per cycle.
- Memory response latency is arbitrary, ≥1 cycle after acceptance. Responses arrive in order, exactly one per accepted request.
- Reset mid-operation discards the queue and any pending state immediately. A response arriving after reset is released, while in IDLE, is ignored.
- Redirect takes effect at the next edge. The first request to redirect_pc can issue:
  - in the following cycle, if the FSM is in IDLE;
  - after the stale response has returned, if the FSM is in KILL.

## Test plan
- Reset release, RESET_PC=0x100, 1-cycle memory, if_ready=1 → requests 0x100, 0x104, … one per cycle; if_pc=0x100 first, if_pc_plus4=0x104, no gaps after fill.
- if_ready=0 held, FQ_DEPTH=4 → exactly 4 entries are queued and imem_req_valid drops. if_ready=1 for one cycle → one pop and one new request, in order.
- 3-cycle memory latency with imem_req_ready toggling → one outstanding request at a time; PCs are sequential; no duplicates or losses.
- redirect_valid to 0x2000 while in WAIT, stale response 2 cycles later → stale data never appears. Next if_pc=0x2000, and if_valid=0 during the redirect cycle.
- redirect_valid in the same cycle as imem_rsp_valid → response dropped, state=IDLE, request 0x2000 on the next cycle.
- fetch_pc=0xFFFF_FFFC, ADDR_W=32 → next request 0x0000_0000, if_pc_plus4=0x0000_0000. Then assert rst mid-WAIT → all outputs reach their reset values asynchronously.
